// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph constants, segment bit order and output-buffer states shared by the seven-segment reader.
package seven_seg_pkg;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} buf_state_e;
endpackage

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode: maps an a..g segment pattern back to its hex nibble, flagging blank and unknown glyphs.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);
  always_comb begin
    nibble_o = 4'h0;
    blank_o = 1'b0;
    err_o = 1'b0;
    case (seg_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
      SEG_BLANK: blank_o = 1'b1;
      default: err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: debounces a multiplexed 7-segment bus, decodes each stable digit onto a
// one-entry valid/ready buffer and keeps a frame register of the latest value per position.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic [3:0]              out_nibble,
  output logic                    out_blank,
  output logic                    out_err,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic                    frame_done
);
  logic [6:0] seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [7:0] cnt_q, cnt_d;
  logic same, accept, hs, load;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic blank, err;
  buf_state_e st_q, st_d;
  logic [IW-1:0] idx_q;
  logic [3:0] nib_q;
  logic blank_q, err_q, ovf_q;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic done_q, done_d;
  // The incoming pair is compared with the last registered one, so the counter reaches
  // STABLE_CYCLES exactly STABLE_CYCLES edges after the pair is first sampled.
  assign same = $onehot(dig_sel) && ({seg_in, dig_sel} == {seg_q, sel_q});
  assign cnt_d = same ? ((cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1) : 8'd0;
  assign accept = same && (cnt_q == 8'(STABLE_CYCLES - 1));
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) idx = sel_q[i] ? IW'(i) : idx;
  end
  seven_seg_glyph_decode u_dec (
    .seg_i    (seg_q),
    .nibble_o (nib),
    .blank_o  (blank),
    .err_o    (err)
  );
  assign hs = (st_q == ST_FULL) && out_ready;
  assign load = accept && ((st_q == ST_EMPTY) || hs);
  assign st_d = load ? ST_FULL : hs ? ST_EMPTY : st_q;
  always_comb begin
    frame_d = frame_q;
    seen_d = seen_q;
    if (accept) begin
      frame_d[4*idx +: 4] = nib;
      seen_d[idx] = 1'b1;
    end
    done_d = &seen_d;
    seen_d = done_d ? '0 : seen_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      st_q <= ST_EMPTY;
      idx_q <= '0;
      nib_q <= '0;
      blank_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      frame_q <= '0;
      seen_q <= '0;
      done_q <= 1'b0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
      cnt_q <= cnt_d;
      st_q <= st_d;
      idx_q <= load ? idx : idx_q;
      nib_q <= load ? nib : nib_q;
      blank_q <= load ? blank : blank_q;
      err_q <= load ? err : err_q;
      ovf_q <= ovf_q | (accept && !load);
      frame_q <= frame_d;
      seen_q <= seen_d;
      done_q <= done_d;
    end
  end
  assign out_valid = (st_q == ST_FULL);
  assign out_idx = idx_q;
  assign out_nibble = nib_q;
  assign out_blank = blank_q;
  assign out_err = err_q;
  assign overflow = ovf_q;
  assign frame_digits = frame_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: directed vectors with hand-computed expectations for the seven-segment reader.
module tb_seven_seg_reader;
  logic clk, rst, out_ready;
  logic [6:0] seg_in;
  logic [3:0] dig_sel;
  logic out_valid, out_blank, out_err, overflow, frame_done;
  logic [1:0] out_idx;
  logic [3:0] out_nibble;
  logic [15:0] frame_digits;
  int n_chk, n_fail, vcnt, fcnt;
  logic [6:0] glyph [4];

  seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .dig_sel      (dig_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_nibble   (out_nibble),
    .out_blank    (out_blank),
    .out_err      (out_err),
    .overflow     (overflow),
    .frame_digits (frame_digits),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      vcnt += int'(out_valid);
      fcnt += int'(frame_done);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_nib"}, out_nibble, 0);
    chk({tag, "_blank"}, out_blank, 0);
    chk({tag, "_err"}, out_err, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_frame"}, frame_digits, 0);
    chk({tag, "_fdone"}, frame_done, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; vcnt = 0; fcnt = 0;
    glyph[0] = 7'b0110000; glyph[1] = 7'b1101101; glyph[2] = 7'b1111001; glyph[3] = 7'b0110011;
    rst = 1'b1; out_ready = 1'b1; seg_in = 7'b0; dig_sel = 4'b0;
    #1;
    chk_all_zero("reset");
    step(2);
    rst = 1'b0;
    // basic dwell: '2' on digit 1
    seg_in = 7'b1101101; dig_sel = 4'b0010; vcnt = 0;
    step(4);
    chk("t1_early", out_valid, 0);
    step(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_idx", out_idx, 1);
    chk("t1_nib", out_nibble, 2);
    chk("t1_blank", out_blank, 0);
    chk("t1_err", out_err, 0);
    chk("t1_frame", frame_digits[7:4], 2);
    step(8);
    chk("t1_once", vcnt, 1);
    // glitch: '3' on digit 0 broken by 1111000
    seg_in = 7'b1111001; dig_sel = 4'b0001; vcnt = 0;
    step(3);
    seg_in = 7'b1111000;
    step(1);
    seg_in = 7'b1111001;
    step(4);
    chk("glitch_none", vcnt, 0);
    step(1);
    chk("glitch_valid", out_valid, 1);
    chk("glitch_nib", out_nibble, 3);
    chk("glitch_idx", out_idx, 0);
    // multi-hot select never accepted
    seg_in = 7'b1011011; dig_sel = 4'b0110; vcnt = 0;
    step(10);
    chk("multihot", vcnt, 0);
    // blank and unknown glyphs
    seg_in = 7'b0000000; dig_sel = 4'b0001;
    step(5);
    chk("blank_valid", out_valid, 1);
    chk("blank_flag", out_blank, 1);
    chk("blank_nib", out_nibble, 0);
    chk("blank_err", out_err, 0);
    seg_in = 7'b1010101; dig_sel = 4'b0100;
    step(5);
    chk("err_valid", out_valid, 1);
    chk("err_flag", out_err, 1);
    chk("err_nib", out_nibble, 0);
    chk("err_idx", out_idx, 2);
    chk("err_blank", out_blank, 0);
    step(2);
    // backpressure
    out_ready = 1'b0;
    seg_in = 7'b1110000; dig_sel = 4'b0001;
    step(5);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_nib", out_nibble, 7);
    chk("bp_ovf_clear", overflow, 0);
    seg_in = 7'b1110111; dig_sel = 4'b0010;
    step(5);
    chk("bp_held_idx", out_idx, 0);
    chk("bp_held_nib", out_nibble, 7);
    chk("bp_ovf", overflow, 1);
    step(3);
    chk("bp_still_valid", out_valid, 1);
    seg_in = 7'b1011011; dig_sel = 4'b0100;
    step(4);
    out_ready = 1'b1;
    step(1);
    chk("bp_swap_valid", out_valid, 1);
    chk("bp_swap_idx", out_idx, 2);
    chk("bp_swap_nib", out_nibble, 5);
    step(1);
    chk("bp_drained", out_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    // frame tracking from a clean reset
    rst = 1'b1;
    step(2);
    rst = 1'b0; fcnt = 0;
    for (int d = 0; d < 4; d++) begin
      seg_in = glyph[d]; dig_sel = 4'(1 << d);
      step(6);
      if (d == 2) chk("frame_partial", fcnt, 0);
    end
    chk("frame_pulse1", fcnt, 1);
    chk("frame_digits", frame_digits, 16'h4321);
    for (int d = 0; d < 4; d++) begin
      seg_in = glyph[d]; dig_sel = 4'(1 << d);
      step(6);
    end
    chk("frame_pulse2", fcnt, 2);
    // async reset while a digit is presented
    out_ready = 1'b0;
    seg_in = 7'b1111011; dig_sel = 4'b0001;
    step(5);
    chk("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    step(2);
    rst = 1'b0; vcnt = 0;
    step(4);
    chk("rst_redwell", vcnt, 0);
    step(1);
    chk("rst_after_valid", out_valid, 1);
    chk("rst_after_nib", out_nibble, 9);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
